ws2812_rx: RTL and testbench
============================

// Module: ws2812_rx
// PURPOSE
//  Single-wire WS2812 NRZ receiver: samples din, times each high pulse, decodes 24-bit GRB words.
//  Behaves like one LED in a chain: latches the first word after a reset gap, ignores later bits until the next gap.
//  Loop-back checker for the ws2812 transmitter, and front end for emulated LED chains on the MCS-4 board.
// PARAMETERS
//  CLK_FRE      27_000_000  clock frequency, Hz (37.04 ns period)
//  T_THRESH     16'd15      high >= 15 clk (555 ns) decodes as 1, else 0
//  MIN_HIGH     16'd4       high < 4 clk (148 ns) is a glitch error
//  MAX_HIGH     16'd40      high > 40 clk (1.48 us) is an error
//  DELAY_RESET  16'd1350    consecutive low clk (50 us) that mark a reset gap
// PORTS
//  clk          in   1   system clock
//  reset_n      in   1   synchronous, active-low reset
//  din          in   1   asynchronous serial input
//  g, r, b      out  8   last decoded word; bits 23:16 = g, 15:8 = r, 7:0 = b
//  valid        out  1   1-clk pulse when g/r/b are updated
//  frame_start  out  1   1-clk pulse when a reset gap is detected
//  err          out  1   1-clk pulse on pulse-width or short-frame error
//  dout         out  1   forwarded stream (see CONFIGURATION)
// BEHAVIOUR
//  Reset (reset_n=0 at posedge clk): g=r=b=0, valid=frame_start=err=dout=0, state=S_IDLE.
//    Counters, shift register and sync flops are cleared. Reset wins over every other event.
//  Input path: din goes through a 2-flop synchroniser to din_s; din_d is din_s delayed one clk.
//    rise = din_s & ~din_d; fall = ~din_s & din_d.
//  low_cnt counts consecutive din_s==0 clocks and saturates at DELAY_RESET.
//    Any clk with din_s==1 clears low_cnt.
//    When low_cnt reaches DELAY_RESET, from any state: frame_start pulse, state=S_ARMED, bit_count=0.
//  States:
//    S_IDLE   wait for a reset gap; all edges ignored; entered after reset and after any error.
//    S_ARMED  rise -> S_HIGH with high_cnt=1.
//    S_HIGH   high_cnt++ while din_s==1, saturating at MAX_HIGH+1.
//             On fall: if high_cnt < MIN_HIGH or > MAX_HIGH: err pulse, state=S_IDLE.
//             Otherwise shift (high_cnt >= T_THRESH) into shreg MSB-first, bit_count++, state=S_LOW.
//             If high_cnt exceeds MAX_HIGH before fall: err pulse at once, state=S_IDLE.
//    S_LOW    rise -> S_HIGH with high_cnt=1. If bit_count==24 -> S_PASS.
//    S_PASS   word already taken; edges ignored until the next reset gap.
//  Word capture: on the fall that completes bit 24, in the same registered update:
//    {g,r,b} <= {shreg[22:0], bit}; valid=1.
//  Latency: valid is high in the 3rd clk after the first clk edge that samples the final din fall.
//  Short frame: a reset gap with 0 < bit_count < 24 raises err and frame_start in the same clk.
//    The partial word is discarded; g/r/b are unchanged.
//  Gap with bit_count==0 or 24 is a normal frame boundary (no err).
//  No duty-cycle check on low time; only the high width is judged.
//  g/r/b hold their value until the next valid; valid/frame_start/err never stay high for 2 clk.
// CONFIGURATION
//  WS2812_RX_FWD_EN defined: dout = din_s registered (one extra clk) while state==S_PASS.
//    dout is 0 in every other state, so downstream sees the stream minus the first 24 bits, delayed 3 clk.
//  WS2812_RX_FWD_EN undefined: dout tied to 0 and no forwarding logic is built.
// STRUCTURE
//  ws2812_pkg holds shared items:
//    - state encodings S_IDLE..S_PASS (3 bits);
//    - timing constants T_THRESH, MIN_HIGH, MAX_HIGH, DELAY_RESET;
//    - WIDTH=24 and the GRB bit-order helpers, shared with the ws2812 transmitter.
//  Sub-module ws2812_rx_sync: 2-flop synchroniser plus rise/fall detect, with clk, reset_n, din -> din_s, rise, fall.
// TESTING
//  Pin timing: T0H=10 clk, T1H=21 clk, T0L=21 clk, T1L=10 clk (ws2812 transmitter timing).
//  1 Release reset_n with din=0 -> frame_start exactly 1350 clk after din_s is low; g/r/b=0, no valid.
//  2 Gap, then GRB A5,3C,0F -> one valid pulse; g=8'hA5, r=8'h3C, b=8'h0F; err never asserts.
//  3 Gap, then 48 bits (A5,3C,0F then 11,22,33) -> one valid with A5/3C/0F.
//    With FWD_EN: dout carries 11,22,33 at the same widths. Without FWD_EN: dout stays 0.
//  4 Gap, 12 bits, 1350 low -> err and frame_start in the same clk; no valid; g/r/b unchanged.
//  5 High pulse of 2 clk -> err, state=S_IDLE, following bits ignored until a gap.
//    High pulse of 45 clk -> err pulse 41 clk after the rise is seen.
//  6 reset_n=0 after 10 bits -> all outputs 0 next clk.
//    A frame sent without a preceding gap is ignored; after a gap, A5,3C,0F decodes correctly.

Source files
------------

// File: rtl/ws2812_pkg.sv
// ws2812_pkg: shared WS2812 state encodings, timing constants and GRB helpers
package ws2812_pkg;
  localparam int CLK_FRE = 27_000_000;
  localparam int WIDTH = 24;
  localparam logic [15:0] T_THRESH = 16'd15;
  localparam logic [15:0] MIN_HIGH = 16'd4;
  localparam logic [15:0] MAX_HIGH = 16'd40;
  // 50 us of low line marks a reset gap
  localparam logic [15:0] DELAY_RESET = 16'(CLK_FRE / 20_000);
  typedef enum logic [2:0] {S_IDLE, S_ARMED, S_HIGH, S_LOW, S_PASS} state_t;
  function automatic logic [WIDTH-1:0] grb_pack(input logic [7:0] g, input logic [7:0] r, input logic [7:0] b);
    return {g, r, b};
  endfunction
endpackage

// File: rtl/ws2812_rx_sync.sv
// ws2812_rx_sync: 2-flop synchroniser for din with rise/fall detection
module ws2812_rx_sync (
  input  logic clk,
  input  logic reset_n,
  input  logic din,
  output logic din_s,
  output logic rise,
  output logic fall
);
  logic s1, din_d;
  always_ff @(posedge clk)
    if (!reset_n) {s1, din_s, din_d} <= '0;
    else {s1, din_s, din_d} <= {din, s1, din_s};
  assign rise = din_s & ~din_d;
  assign fall = ~din_s & din_d;
endmodule

// File: rtl/ws2812_rx.sv
// ws2812_rx: WS2812 NRZ receiver latching the first GRB word after a reset gap
// WS2812_RX_FWD_EN forwards the stream after the first word on dout
module ws2812_rx
  import ws2812_pkg::*;
(
  input  logic       clk,
  input  logic       reset_n,
  input  logic       din,
  output logic [7:0] g,
  output logic [7:0] r,
  output logic [7:0] b,
  output logic       valid,
  output logic       frame_start,
  output logic       err,
  output logic       dout
);
  logic din_s, rise, fall, gap, bit_val, bad;
  state_t state;
  logic [15:0] low_cnt, high_cnt;
  logic [4:0] bit_count;
  logic [WIDTH-2:0] shreg;
  ws2812_rx_sync u_sync (.clk(clk), .reset_n(reset_n), .din(din), .din_s(din_s), .rise(rise), .fall(fall));
  assign gap = ~din_s && low_cnt == DELAY_RESET - 16'd1;
  assign bit_val = high_cnt >= T_THRESH;
  assign bad = high_cnt < MIN_HIGH || high_cnt > MAX_HIGH;
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state <= S_IDLE;
      low_cnt <= '0;
      high_cnt <= '0;
      bit_count <= '0;
      shreg <= '0;
      {g, r, b} <= '0;
      valid <= 1'b0;
      frame_start <= 1'b0;
      err <= 1'b0;
    end else begin
      valid <= 1'b0;
      frame_start <= 1'b0;
      err <= 1'b0;
      low_cnt <= din_s ? '0 : (low_cnt == DELAY_RESET ? low_cnt : low_cnt + 16'd1);
      if (gap) begin
        frame_start <= 1'b1;
        err <= bit_count != '0 && bit_count != 5'(WIDTH);
        state <= S_ARMED;
        bit_count <= '0;
      end else begin
        case (state)
          S_ARMED: if (rise) begin
            state <= S_HIGH;
            high_cnt <= 16'd1;
          end
          S_HIGH: if (fall) begin
            if (bad) begin
              err <= 1'b1;
              state <= S_IDLE;
              bit_count <= '0;
            end else begin
              shreg <= {shreg[WIDTH-3:0], bit_val};
              bit_count <= bit_count + 5'd1;
              state <= S_LOW;
              if (bit_count == 5'(WIDTH - 1)) begin
                {g, r, b} <= {shreg, bit_val};
                valid <= 1'b1;
              end
            end
          end else begin
            // overlong pulse is flagged the clock it passes MAX_HIGH, not at its fall
            high_cnt <= high_cnt + 16'd1;
            if (high_cnt == MAX_HIGH) begin
              err <= 1'b1;
              state <= S_IDLE;
              bit_count <= '0;
            end
          end
          S_LOW: if (bit_count == 5'(WIDTH)) state <= S_PASS;
            else if (rise) begin
              state <= S_HIGH;
              high_cnt <= 16'd1;
            end
          default: ;
        endcase
      end
    end
  end
`ifdef WS2812_RX_FWD_EN
  always_ff @(posedge clk)
    if (!reset_n) dout <= 1'b0;
    else dout <= state == S_PASS && din_s;
`else
  assign dout = 1'b0;
`endif
endmodule

// File: tb/tb_ws2812_rx.sv
// tb_ws2812_rx: scoreboard bench for ws2812_rx
module tb_ws2812_rx;
  import ws2812_pkg::*;
  logic clk = 1'b0, reset_n = 1'b0, din = 1'b0;
  logic [7:0] g, r, b;
  logic valid, frame_start, err, dout;
  int vectors = 0, miscompares = 0;
  int n_valid = 0, n_err = 0, n_fs = 0, n_both = 0, n_dout = 0;
  logic [2:0] pv = '0;
  logic [23:0] q[$];
  logic [23:0] w1, w2;
  int n, v0, e0, f0, b0, d0, exp_dout;
  ws2812_rx dut (.clk(clk), .reset_n(reset_n), .din(din), .g(g), .r(r), .b(b), .valid(valid),
                 .frame_start(frame_start), .err(err), .dout(dout));
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  function automatic int hi_time(input logic [23:0] w);
    int t = 0;
    for (int i = 0; i < 24; i++) t += w[i] ? 21 : 10;
    return t;
  endfunction
  task automatic send_bit(input logic bv);
    din = 1'b1;
    repeat (bv ? 21 : 10) @(negedge clk);
    din = 1'b0;
    repeat (bv ? 10 : 21) @(negedge clk);
  endtask
  task automatic send_bits(input logic [23:0] w, input int nb);
    for (int i = 23; i > 23 - nb; i--) send_bit(w[i]);
  endtask
  task automatic gap();
    din = 1'b0;
    repeat (1400) @(negedge clk);
  endtask
  always @(negedge clk) begin
    if (!reset_n) pv <= '0;
    else begin
      if (valid) begin
        if (q.size() != 0) chk("word", {g, r, b}, q.pop_front());
        else chk("spurious_valid", valid, 1'b0);
      end
      if (pv != '0) chk("pulse_width", {valid, frame_start, err} & pv, 3'b0);
      pv <= {valid, frame_start, err};
      n_valid <= n_valid + int'(valid);
      n_err <= n_err + int'(err);
      n_fs <= n_fs + int'(frame_start);
      n_both <= n_both + int'(err && frame_start);
      n_dout <= n_dout + int'(dout);
    end
  end
  initial begin
    #3ms;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end
  initial begin
    w1 = grb_pack(8'hA5, 8'h3C, 8'h0F);
    w2 = grb_pack(8'h11, 8'h22, 8'h33);
    repeat (3) @(negedge clk);
    chk("rst_grb", {g, r, b}, 24'h0);
    chk("rst_flags", {valid, frame_start, err, dout}, 4'h0);
    reset_n = 1'b1;
    n = 0;
    while (!frame_start && n < 2000) begin
      @(posedge clk);
      #1;
      n++;
    end
    chk("gap_latency", n, 1350);
    chk("t1_grb", {g, r, b}, 24'h0);
    @(negedge clk);
    // single frame, with valid latency measured off the last fall
    v0 = n_valid; e0 = n_err;
    q.push_back(w1);
    send_bits(w1, 23);
    din = 1'b1;
    repeat (21) @(negedge clk);
    din = 1'b0;
    n = 0;
    while (!valid && n < 10) begin
      @(posedge clk);
      #1;
      n++;
    end
    chk("t2_latency", n, 3);
    @(negedge clk);
    repeat (30) @(negedge clk);
    chk("t2_valid_cnt", n_valid - v0, 1);
    chk("t2_g", g, 8'hA5);
    chk("t2_r", r, 8'h3C);
    chk("t2_b", b, 8'h0F);
    chk("t2_err_cnt", n_err - e0, 0);
    // two words: only the first is latched, the second is forwarded
    gap();
    v0 = n_valid; d0 = n_dout;
    q.push_back(w1);
    send_bits(w1, 24);
    send_bits(w2, 24);
    repeat (10) @(negedge clk);
`ifdef WS2812_RX_FWD_EN
    exp_dout = hi_time(w2);
`else
    exp_dout = 0;
`endif
    chk("t3_valid_cnt", n_valid - v0, 1);
    chk("t3_grb", {g, r, b}, w1);
    chk("t3_dout_high", n_dout - d0, exp_dout);
    // short frame
    gap();
    v0 = n_valid; e0 = n_err; f0 = n_fs; b0 = n_both;
    send_bits(w2, 12);
    gap();
    chk("t4_err_cnt", n_err - e0, 1);
    chk("t4_fs_cnt", n_fs - f0, 1);
    chk("t4_err_with_fs", n_both - b0, 1);
    chk("t4_valid_cnt", n_valid - v0, 0);
    chk("t4_grb", {g, r, b}, w1);
    // glitch pulse, then a frame that must be ignored
    v0 = n_valid; e0 = n_err;
    din = 1'b1;
    repeat (2) @(negedge clk);
    din = 1'b0;
    repeat (30) @(negedge clk);
    send_bits(w2, 24);
    chk("t5_glitch_err", n_err - e0, 1);
    chk("t5_ignored_valid", n_valid - v0, 0);
    gap();
    e0 = n_err;
    din = 1'b1;
    n = 0;
    while (!err && n < 100) begin
      @(posedge clk);
      #1;
      n++;
    end
    chk("t5_long_latency", n, 43);
    repeat (2) @(negedge clk);
    din = 1'b0;
    repeat (30) @(negedge clk);
    chk("t5_long_err", n_err - e0, 1);
    chk("t5_grb", {g, r, b}, w1);
    // reset mid-frame, then a frame without a gap, then a proper one
    gap();
    send_bits(w2, 10);
    reset_n = 1'b0;
    @(posedge clk);
    #1;
    chk("t6_reset_outs", {g, r, b, valid, frame_start, err, dout}, 28'h0);
    @(negedge clk);
    reset_n = 1'b1;
    v0 = n_valid;
    send_bits(w2, 24);
    repeat (30) @(negedge clk);
    chk("t6_nogap_valid", n_valid - v0, 0);
    gap();
    q.push_back(w1);
    send_bits(w1, 24);
    repeat (30) @(negedge clk);
    chk("t6_valid_cnt", n_valid - v0, 1);
    chk("t6_grb", {g, r, b}, w1);
    chk("queue_empty", q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
